// File: rtl/double_ask_rx.sv
// 2ASK receiver: counts above-threshold samples per bit window and decides each bit by a minimum hit count.
// Define DOUBLE_ASK_RX_BIT_OUT_EN to add the per-bit outputs bit_out and bit_strobe.
module double_ask_rx #(
  parameter int unsigned B_FREQ  = 'd49,
  parameter logic [15:0] THRESH  = 16'd256,
  parameter int unsigned MIN_CNT = 'd25
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] mod_in,
  input  logic        frame_sync,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy
`ifdef DOUBLE_ASK_RX_BIT_OUT_EN
  ,
  output logic        bit_out,
  output logic        bit_strobe
`endif
);

  localparam int unsigned FREQ_W = 6;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned HIT_W  = 7;
  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e              state_q;
  logic [FREQ_W-1:0]   freq_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [HIT_W-1:0]    hit_cnt_q;
  logic [WORD_W-1:0]   shift_q;
  logic [WORD_W-1:0]   data_out_q;
  logic                data_valid_q;
  logic                busy_q;

  logic                hit_c;
  logic [HIT_W:0]      hit_sum_c;
  logic [HIT_W-1:0]    hit_sat_c;
  logic                win_close_c;
  logic                last_win_c;
  logic                bit_c;
  logic [WORD_W-1:0]   shift_d;

  // Window bookkeeping; the closing sample is folded into the decision.
  always_comb begin
    hit_c       = (mod_in > THRESH);
    hit_sum_c   = (HIT_W+1)'(hit_cnt_q) + (HIT_W+1)'(hit_c);
    hit_sat_c   = (hit_cnt_q == {HIT_W{1'b1}}) ? hit_cnt_q : hit_sum_c[HIT_W-1:0];
    win_close_c = (state_q == RECV) && (freq_cnt_q == FREQ_W'(B_FREQ));
    last_win_c  = win_close_c && (bit_cnt_q == BIT_W'(WORD_W));
    bit_c       = (hit_sum_c >= (HIT_W+1)'(MIN_CNT));
    shift_d     = {shift_q[WORD_W-2:0], bit_c};
  end

  // Receive FSM; a sampled frame_sync always wins and restarts window 1.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      freq_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (state_q == RECV) begin
        if (win_close_c) begin
          freq_cnt_q <= '0;
          hit_cnt_q  <= '0;
          bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
          shift_q    <= shift_d;
          if (last_win_c) begin
            data_out_q   <= shift_d;
            data_valid_q <= 1'b1;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
          end
        end else begin
          freq_cnt_q <= freq_cnt_q + FREQ_W'(1);
          hit_cnt_q  <= hit_sat_c;
        end
      end
      if (frame_sync) begin
        state_q    <= RECV;
        busy_q     <= 1'b1;
        freq_cnt_q <= '0;
        bit_cnt_q  <= BIT_W'(1);
        hit_cnt_q  <= '0;
        shift_q    <= '0;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;

`ifdef DOUBLE_ASK_RX_BIT_OUT_EN
  logic bit_out_q;
  logic bit_strobe_q;

  // Per-bit strobe, suppressed for a window cut short by an aborting frame_sync.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bit_out_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
    end else begin
      bit_strobe_q <= win_close_c && (!frame_sync || last_win_c);
      if (win_close_c) begin
        bit_out_q <= bit_c;
      end
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_strobe = bit_strobe_q;
`endif

endmodule

// File: tb/tb_double_ask_rx.sv
// Bench for double_ask_rx: randomized ASK frames checked every cycle against a sample-log reference model.
module tb_double_ask_rx;

  localparam int BIT_LEN   = 50;
  localparam int FRAME_LEN = 16 * BIT_LEN;
  localparam int MINC      = 25;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [15:0] mod_in;
  logic        frame_sync;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
`ifdef DOUBLE_ASK_RX_BIT_OUT_EN
  logic        bit_out;
  logic        bit_strobe;
`endif

  double_ask_rx #(
    .B_FREQ (49),
    .THRESH (16'd256),
    .MIN_CNT(25)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mod_in    (mod_in),
    .frame_sync(frame_sync),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy)
`ifdef DOUBLE_ASK_RX_BIT_OUT_EN
    ,
    .bit_out   (bit_out),
    .bit_strobe(bit_strobe)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          sync_edge = 0;
  int          wcnt [16];

  bit          m_active = 1'b0;
  int          m_n      = 0;
  bit          hits [FRAME_LEN];
  logic [15:0] exp_data  = 16'h0000;
  logic        exp_valid = 1'b0;
  logic        exp_busy  = 1'b0;

  logic [15:0] vdata [$];
  int          vedge [$];
  logic        vbusy [$];
`ifdef DOUBLE_ASK_RX_BIT_OUT_EN
  int          sedge [$];
  logic        sbit  [$];
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference decode: per-window count of above-threshold samples against MINC, bit 1 in the MSB.
  function automatic logic [15:0] decode();
    logic [15:0] w;
    w = 16'h0000;
    for (int b = 0; b < 16; b++) begin
      int s;
      s = 0;
      for (int j = 0; j < BIT_LEN; j++) s += int'(hits[b*BIT_LEN + j]);
      w[15-b] = (s >= MINC);
    end
    return w;
  endfunction

  function automatic logic [15:0] sample(input bit above);
    if (above) return ($urandom_range(7, 0) == 0) ? 16'd257 : 16'($urandom_range(65535, 257));
    return ($urandom_range(7, 0) == 0) ? 16'd256 : 16'($urandom_range(256, 0));
  endfunction

  // Reference model: logs the samples of the active frame and decodes after the 800th.
  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (!sys_rst_n) begin
        m_active  = 1'b0;
        m_n       = 0;
        exp_data  = 16'h0000;
        exp_valid = 1'b0;
      end else begin
        exp_valid = 1'b0;
        if (m_active) begin
          hits[m_n] = (mod_in > 16'd256);
          m_n++;
          if (m_n == FRAME_LEN) begin
            exp_data  = decode();
            exp_valid = 1'b1;
            m_active  = 1'b0;
          end
        end
        if (frame_sync) begin
          m_active = 1'b1;
          m_n      = 0;
        end
      end
      exp_busy = m_active;
    end
  end

  // Per-cycle compare and event logging, away from the active edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (cyc > 0) begin
        chk("data_out", 32'(data_out), 32'(exp_data));
        chk("data_valid", 32'(data_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_busy));
      end
      if (data_valid === 1'b1) begin
        vdata.push_back(data_out);
        vedge.push_back(cyc);
        vbusy.push_back(busy);
      end
`ifdef DOUBLE_ASK_RX_BIT_OUT_EN
      if (bit_strobe === 1'b1) begin
        sedge.push_back(cyc);
        sbit.push_back(bit_out);
      end
`endif
    end
  end

  task automatic set_word(input logic [15:0] w, input bit noisy);
    for (int b = 0; b < 16; b++) begin
      if (w[15-b]) wcnt[b] = noisy ? int'($urandom_range(50, 25)) : 50;
      else         wcnt[b] = noisy ? int'($urandom_range(24, 0)) : 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      frame_sync = 1'b0;
      mod_in     = sample(1'b1);
      @(negedge sys_clk);
    end
  endtask

  // Drives nsamp window samples from wcnt; hits are rotated randomly inside each window.
  task automatic send(input int nsamp, input bit start_sync, input bit end_sync);
    int rot;
    rot = 0;
    if (start_sync) begin
      frame_sync = 1'b1;
      mod_in     = sample(1'b1);
      sync_edge  = cyc + 1;
      @(negedge sys_clk);
    end
    for (int i = 0; i < nsamp; i++) begin
      if (i % BIT_LEN == 0) rot = int'($urandom_range(BIT_LEN - 1, 0));
      frame_sync = end_sync && (i == nsamp - 1);
      if (frame_sync) sync_edge = cyc + 1;
      mod_in = sample(((i % BIT_LEN + rot) % BIT_LEN) < wcnt[i / BIT_LEN]);
      @(negedge sys_clk);
    end
    frame_sync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nv0;
    logic [15:0] w;
    sys_rst_n  = 1'b0;
    frame_sync = 1'b0;
    mod_in     = 16'h0000;
    repeat (3) @(negedge sys_clk);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    sys_rst_n = 1'b1;

    // Idle carrier must not produce anything.
    idle(60);
    chk("idle_no_valid", 32'(vdata.size()), 32'h0);

    nv0 = vdata.size();
    set_word(16'hA5C3, 1'b0);
    send(FRAME_LEN, 1'b1, 1'b0);
    idle(3);
    chk("a5c3_count", 32'(vdata.size() - nv0), 32'd1);
    if (vdata.size() > nv0) begin
      chk("a5c3_data", 32'(vdata[nv0]), 32'hA5C3);
      chk("a5c3_latency", 32'(vedge[nv0] + 1 - sync_edge), 32'd801);
      chk("a5c3_busy_low", 32'(vbusy[nv0]), 32'h0);
    end

    nv0 = vdata.size();
    set_word(16'hFFFF, 1'b0);
    send(FRAME_LEN, 1'b1, 1'b1);
    set_word(16'h0000, 1'b0);
    send(FRAME_LEN, 1'b0, 1'b0);
    idle(3);
    chk("b2b_count", 32'(vdata.size() - nv0), 32'd2);
    if (vdata.size() > nv0 + 1) begin
      chk("b2b_first", 32'(vdata[nv0]), 32'hFFFF);
      chk("b2b_second", 32'(vdata[nv0+1]), 32'h0000);
    end

    nv0 = vdata.size();
    set_word(16'h1234, 1'b1);
    send(300, 1'b1, 1'b1);
    set_word(16'h8001, 1'b1);
    send(FRAME_LEN, 1'b0, 1'b0);
    idle(3);
    chk("abort_count", 32'(vdata.size() - nv0), 32'd1);
    if (vdata.size() > nv0) chk("abort_data", 32'(vdata[nv0]), 32'h8001);

    nv0 = vdata.size();
    set_word(16'($urandom), 1'b1);
    send(400, 1'b1, 1'b0);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("midrst_data_out", 32'(data_out), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    idle(900);
    chk("midrst_no_valid", 32'(vdata.size() - nv0), 32'h0);

    // Threshold-count boundaries: 25 -> 1, 24 -> 0, plus clean 50 and 0 windows.
    nv0 = vdata.size();
    wcnt = '{25, 24, 24, 25, 50, 0, 25, 25, 24, 24, 24, 25, 0, 50, 24, 25};
    send(FRAME_LEN, 1'b1, 1'b0);
    idle(3);
    chk("bound_count", 32'(vdata.size() - nv0), 32'd1);
    if (vdata.size() > nv0) chk("bound_data", 32'(vdata[nv0]), 32'h9B15);

    for (int r = 0; r < 6; r++) begin
      nv0 = vdata.size();
      w   = 16'($urandom);
      set_word(w, 1'b1);
      send(FRAME_LEN, 1'b1, 1'b0);
      idle(2 + int'($urandom_range(8, 0)));
      chk("rand_count", 32'(vdata.size() - nv0), 32'd1);
      if (vdata.size() > nv0) chk("rand_data", 32'(vdata[nv0]), 32'(w));
    end

`ifdef DOUBLE_ASK_RX_BIT_OUT_EN
    begin
      int ns0;
      ns0 = sedge.size();
      set_word(16'h8000, 1'b0);
      send(FRAME_LEN, 1'b1, 1'b0);
      idle(3);
      chk("strobe_count", 32'(sedge.size() - ns0), 32'd16);
      if (sedge.size() >= ns0 + 16) begin
        for (int j = 0; j < 16; j++) begin
          chk("strobe_bit", 32'(sbit[ns0+j]), (j == 0) ? 32'h1 : 32'h0);
          if (j > 0) chk("strobe_gap", 32'(sedge[ns0+j] - sedge[ns0+j-1]), 32'd50);
        end
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
